instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the instruction-memory address width.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 5'b11111, giving the opcode that stops fetching.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; both are fixed.
REQ-004 ClockInput  in  1  system clock; all state changes on the rising edge.
REQ-005 ResetInput  in  1  asynchronous, active-low reset.
REQ-006 RunInput  in  1  enable; 1 = fetch continuously.
REQ-007 MemAddressOutput  out  ADDR_WIDTH  instruction-memory address; always equal to PC.
REQ-008 MemReadEnableOutput  out  1  read strobe to the synchronous instruction ROM.
REQ-009 MemDataInput  in  22  instruction word: [21:17] opcode, [16] addressing mode, [15:0] operand; valid one cycle after the strobe.
REQ-010 OpecodeOutput  out  5  opcode to the decoder.
REQ-011 AddressingModeOutput  out  1  addressing mode to the decoder.
REQ-012 OperandOutput  out  16  operand to the decoder.
REQ-013 ValidOutput  out  1  the three decoder fields hold a valid instruction.
REQ-014 ReadyInput  in  1  decoder accepts the instruction.
REQ-015 JumpFlagInput  in  1  branch taken for the presented instruction.
REQ-016 JumpAddressInput  in  ADDR_WIDTH  branch target.
REQ-017 PcOutput  out  ADDR_WIDTH  current program counter.
REQ-018 HaltOutput  out  1  HALT_OPCODE has been consumed.

Function
REQ-019 The FSM SHALL have five states: IDLE, FETCH, LOAD, PRESENT, HALTED.
REQ-020 IDLE: when RunInput=1, next state SHALL be FETCH; otherwise it SHALL stay in IDLE.
REQ-021 FETCH: MemReadEnableOutput SHALL be 1 for exactly this cycle; next state SHALL be LOAD.
REQ-022 LOAD: the block SHALL register MemDataInput into the three decoder fields, set PC to PC+1 modulo 2^ADDR_WIDTH, and set ValidOutput to 1; next state SHALL be PRESENT.
REQ-023 PRESENT: the decoder fields and ValidOutput SHALL hold stable while ReadyInput=0.
REQ-024 PRESENT with ReadyInput=1 (the handshake cycle): ValidOutput SHALL go to 0 on the next edge.
REQ-025 In the handshake cycle, if OpecodeOutput=HALT_OPCODE, next state SHALL be HALTED; JumpFlagInput SHALL be ignored.
REQ-026 Otherwise, in the handshake cycle, if JumpFlagInput=1, PC SHALL be loaded with JumpAddressInput.
REQ-027 Otherwise, after the handshake, next state SHALL be FETCH if RunInput=1, else IDLE.
REQ-028 JumpFlagInput SHALL be ignored in every state and cycle other than the handshake cycle.
REQ-029 If RunInput falls during FETCH or LOAD, the in-flight fetch SHALL complete and be presented; no new fetch SHALL start.
REQ-030 HALTED: HaltOutput=1, ValidOutput=0, MemReadEnableOutput=0; the state SHALL be left only by reset.
REQ-031 Minimum issue interval SHALL be 3 cycles (FETCH, LOAD, PRESENT with ReadyInput already 1).
REQ-032 PC SHALL wrap from 2^ADDR_WIDTH-1 to 0 with no flag.
REQ-033 MemAddressOutput and PcOutput SHALL equal the PC register in every state.

Reset
REQ-034 ResetInput=0 SHALL immediately, without waiting for a clock edge, force state IDLE, PC=0, all decoder fields=0, and ValidOutput, MemReadEnableOutput and HaltOutput=0.
REQ-035 Reset asserted in any state, including mid-fetch, SHALL discard the in-flight instruction.
REQ-036 After ResetInput rises, the first FETCH SHALL occur no earlier than the second rising edge.

Verification
REQ-037 ROM[0]=22'h06_0005, ROM[1]=22'h0C_1234, RunInput=1, ReadyInput=1 -> opcode 5'b00011/mode 0/operand 16'h0005 valid, then 5'b00110/0/16'h1234; ValidOutput pulses 1 cycle every 3 cycles.
REQ-038 ReadyInput held 0 for 5 cycles in PRESENT -> fields and ValidOutput constant; PC=1 throughout; no read strobe.
REQ-039 JumpFlagInput=1 and JumpAddressInput=8'h40 in the handshake cycle -> next MemAddressOutput=8'h40 on the read strobe; JumpFlagInput pulse in a FETCH cycle has no effect.
REQ-040 ROM[2] opcode=5'b11111 -> after its handshake HaltOutput=1, no further strobes for 20 cycles even with RunInput=1; reset then clears HaltOutput and sets PC=0.
REQ-041 PC preloaded to 8'hFF via jump -> after the LOAD state, PC=8'h00.
REQ-042 ResetInput pulsed low during LOAD -> ValidOutput stays 0, PC=0 and fields=0 with no clock edge needed.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks the program counter through a synchronous
// instruction ROM and presents each decoded word to the decoder with a
// valid/ready handshake. Branches are taken at the handshake, and a halt
// opcode parks the unit until the next reset.
module instruction_fetch #(
    parameter int         ADDR_WIDTH  = 8,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic                  ClockInput,
    input  logic                  ResetInput,
    input  logic                  RunInput,
    output logic [ADDR_WIDTH-1:0] MemAddressOutput,
    output logic                  MemReadEnableOutput,
    input  logic [21:0]           MemDataInput,
    output logic [4:0]            OpecodeOutput,
    output logic                  AddressingModeOutput,
    output logic [15:0]           OperandOutput,
    output logic                  ValidOutput,
    input  logic                  ReadyInput,
    input  logic                  JumpFlagInput,
    input  logic [ADDR_WIDTH-1:0] JumpAddressInput,
    output logic [ADDR_WIDTH-1:0] PcOutput,
    output logic                  HaltOutput
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        PRESENT = 3'd3,
        HALTED  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [4:0]              opcode_q, opcode_d;
    logic                    mode_q, mode_d;
    logic [15:0]             operand_q, operand_d;

    // State, PC and decoder-field registers; reset discards any in-flight word.
    always_ff @(posedge ClockInput or negedge ResetInput) begin
        if (!ResetInput) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            mode_q    <= 1'b0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            mode_q    <= mode_d;
            operand_q <= operand_d;
        end
    end

    // Next-state logic: the ROM word arrives during LOAD, branch/halt decided at the handshake.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        mode_d    = mode_q;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (RunInput) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                opcode_d  = MemDataInput[21:17];
                mode_d    = MemDataInput[16];
                operand_d = MemDataInput[15:0];
                pc_d      = pc_q + PC_ONE;
                state_d   = PRESENT;
            end
            PRESENT: begin
                if (ReadyInput) begin
                    if (opcode_q == HALT_OPCODE) begin
                        // A halt wins over any branch offered in the same cycle.
                        state_d = HALTED;
                    end else begin
                        if (JumpFlagInput) pc_d = JumpAddressInput;
                        state_d = RunInput ? FETCH : IDLE;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded straight from state so reset clears them without a clock edge.
    assign MemReadEnableOutput  = (state_q == FETCH);
    assign ValidOutput          = (state_q == PRESENT);
    assign HaltOutput           = (state_q == HALTED);
    assign MemAddressOutput     = pc_q;
    assign PcOutput             = pc_q;
    assign OpecodeOutput        = opcode_q;
    assign AddressingModeOutput = mode_q;
    assign OperandOutput        = operand_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a synchronous ROM model plus directed and
// randomized scenarios checked against an instruction-sequence model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  addr;
    logic        re;
    logic [21:0] mdata;
    logic [4:0]  opc;
    logic        mode;
    logic [15:0] opnd;
    logic        valid;
    logic        ready;
    logic        jump;
    logic [7:0]  jaddr;
    logic [7:0]  pc;
    logic        halt;

    logic [21:0] rom [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the strobe.
    always_ff @(posedge clk) begin
        if (re) mdata <= rom[addr];
    end

    instruction_fetch #(.ADDR_WIDTH(8), .HALT_OPCODE(5'b11111)) dut (
        .ClockInput          (clk),
        .ResetInput          (rst_n),
        .RunInput            (run),
        .MemAddressOutput    (addr),
        .MemReadEnableOutput (re),
        .MemDataInput        (mdata),
        .OpecodeOutput       (opc),
        .AddressingModeOutput(mode),
        .OperandOutput       (opnd),
        .ValidOutput         (valid),
        .ReadyInput          (ready),
        .JumpFlagInput       (jump),
        .JumpAddressInput    (jaddr),
        .PcOutput            (pc),
        .HaltOutput          (halt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 22'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        ready = 1'b0;
        jump  = 1'b0;
        jaddr = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        run = 1'b1; ready = 1'b1; jump = 1'b0; jaddr = 8'h00;
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({re, valid, halt, pc, addr, opc, mode, opnd} !== 42'h0) begin
            errors++;
            $display("FAIL reset_outputs got re=%b v=%b h=%b pc=%h a=%h op=%h m=%b opnd=%h want all 0",
                     re, valid, halt, pc, addr, opc, mode, opnd);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (re !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_strobe got %b want 0", re);
        end
        step();
        do_reset();
    endtask

    task automatic test_basic();
        int first = -1, second = -1, nvalid = 0;
        logic [21:0] w1, w2;
        clear_rom();
        rom[0] = 22'h06_0005;
        rom[1] = 22'h0C_1234;
        do_reset();
        run = 1'b1; ready = 1'b1;
        w1 = 22'h0; w2 = 22'h0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (valid) begin
                nvalid++;
                if (first < 0) begin first = c; w1 = {opc, mode, opnd}; end
                else if (second < 0) begin second = c; w2 = {opc, mode, opnd}; end
            end
        end
        checks++;
        if (w1 !== {5'b00011, 1'b0, 16'h0005}) begin
            errors++; $display("FAIL basic_first got %h want %h", w1, {5'b00011, 1'b0, 16'h0005});
        end
        checks++;
        if (w2 !== {5'b00110, 1'b0, 16'h1234}) begin
            errors++; $display("FAIL basic_second got %h want %h", w2, {5'b00110, 1'b0, 16'h1234});
        end
        checks++;
        if (second - first !== 3 || nvalid !== 3) begin
            errors++; $display("FAIL basic_interval got gap=%0d pulses=%0d want gap=3 pulses=3", second - first, nvalid);
        end
    endtask

    task automatic test_stall();
        int waited = 0;
        clear_rom();
        rom[0] = 22'h2A_BEEF;
        do_reset();
        run = 1'b1; ready = 1'b0;
        while (!valid && waited < 10) begin step(); waited++; end
        checks++;
        if (valid !== 1'b1) begin
            errors++; $display("FAIL stall_valid_timeout got %b want 1", valid);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({valid, re, pc, opc, mode, opnd} !== {1'b1, 1'b0, 8'h01, rom[0]}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b re=%b pc=%h w=%h want v=1 re=0 pc=01 w=%h",
                         c, valid, re, pc, {opc, mode, opnd}, rom[0]);
            end
        end
        ready = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got %b want 0", valid);
        end
    endtask

    task automatic test_jump();
        int waited = 0;
        clear_rom();
        do_reset();
        run = 1'b1; ready = 1'b1;
        while (!valid && waited < 10) begin step(); waited++; end
        jump = 1'b1; jaddr = 8'h40;
        step();
        jump = 1'b0; jaddr = 8'h00;
        checks++;
        if ({re, addr} !== {1'b1, 8'h40}) begin
            errors++; $display("FAIL jump_target got re=%b a=%h want re=1 a=40", re, addr);
        end
        // Branch request during FETCH must be ignored.
        jump = 1'b1; jaddr = 8'h10;
        step();
        jump = 1'b0; jaddr = 8'h00;
        step();
        checks++;
        if ({valid, pc} !== {1'b1, 8'h41}) begin
            errors++; $display("FAIL jump_ignored_fetch got v=%b pc=%h want v=1 pc=41", valid, pc);
        end
        jump = 1'b1; jaddr = 8'hFF;
        step();
        jump = 1'b0; jaddr = 8'h00;
        checks++;
        if ({re, addr} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL jump_ff got re=%b a=%h want re=1 a=ff", re, addr);
        end
        step();
        step();
        checks++;
        if ({valid, pc} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL pc_wrap got v=%b pc=%h want v=1 pc=00", valid, pc);
        end
    endtask

    task automatic test_halt();
        int strobes = 0, waited = 0;
        clear_rom();
        rom[0] = 22'h06_0005;
        rom[1] = 22'h0C_1234;
        rom[2] = {5'b11111, 1'b0, 16'h0000};
        do_reset();
        run = 1'b1; ready = 1'b1;
        while (!halt && waited < 30) begin
            step();
            waited++;
            if (re) strobes++;
            // Offer a branch alongside the halt word; it must lose.
            jump  = valid && (opc == 5'b11111);
            jaddr = 8'h77;
        end
        jump = 1'b0;
        checks++;
        if ({halt, pc} !== {1'b1, 8'h03} || strobes !== 3) begin
            errors++; $display("FAIL halt_reach got h=%b pc=%h strobes=%0d want h=1 pc=03 strobes=3", halt, pc, strobes);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if ({re, valid, halt} !== 3'b001) begin
                errors++; $display("FAIL halt_hold cyc=%0d got re=%b v=%b h=%b want 0 0 1", c, re, valid, halt);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({halt, pc} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL halt_reset got h=%b pc=%h want h=0 pc=00", halt, pc);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        int waited = 0;
        clear_rom();
        rom[0] = 22'h03_5A5A;
        rom[1] = 22'h2B_3C3C;
        do_reset();
        run = 1'b1; ready = 1'b1;
        while (!valid && waited < 10) begin step(); waited++; end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, pc, opc, mode, opnd} !== 31'h0) begin
            errors++; $display("FAIL reset_load got v=%b pc=%h w=%h want all 0", valid, pc, {opc, mode, opnd});
        end
        step();
        checks++;
        if ({valid, re, pc} !== 10'h0) begin
            errors++; $display("FAIL reset_load_edge got v=%b re=%b pc=%h want all 0", valid, re, pc);
        end
        rst_n = 1'b1;
    endtask

    // Random traffic against a model of the instruction stream: each strobe
    // must address the model's next PC, and each handshake must hand over the
    // ROM word at the address last fetched.
    task automatic test_random();
        logic [7:0] exp_addr = 8'h00;
        logic [7:0] last = 8'h00;
        int hs = 0;
        for (int i = 0; i < 256; i++)
            rom[i] = {5'($urandom_range(0, 30)), 17'($urandom)};
        do_reset();
        run = 1'b1; ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && hs < 40; cyc++) begin
            step();
            if (re) begin
                checks++;
                if (addr !== exp_addr || valid !== 1'b0) begin
                    errors++; $display("FAIL rand_fetch got a=%h v=%b want a=%h v=0", addr, valid, exp_addr);
                end
                last = exp_addr;
            end
            if (valid) begin
                checks++;
                if (pc !== 8'(last + 8'h01)) begin
                    errors++; $display("FAIL rand_pc got %h want %h", pc, 8'(last + 8'h01));
                end
            end
            ready = ($urandom_range(0, 2) != 0);
            run   = ($urandom_range(0, 9) != 0);
            jump  = ($urandom_range(0, 1) != 0);
            jaddr = 8'($urandom);
            if (valid && ready) begin
                checks++;
                if ({opc, mode, opnd} !== rom[last]) begin
                    errors++; $display("FAIL rand_word got %h want %h", {opc, mode, opnd}, rom[last]);
                end
                exp_addr = jump ? jaddr : 8'(last + 8'h01);
                hs++;
            end
        end
        checks++;
        if (hs !== 40) begin
            errors++; $display("FAIL rand_progress got %0d want 40", hs);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        run   = 1'b0;
        ready = 1'b0;
        jump  = 1'b0;
        jaddr = 8'h00;
        clear_rom();
        test_reset();
        test_basic();
        test_stall();
        test_jump();
        test_halt();
        test_reset_mid_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
